rtc_field_editor: RTL and testbench



---
 rtl/rtc_field_editor.sv | 217 +++++++++++++++++++++
 tb/tb_rtc_field_editor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_field_editor.sv
// rtc_field_editor: cursor-driven BCD time-field editor with a two-phase RTC bus write.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   enable                     editor active; low returns to idle
//   up/down/left/right         single-cycle edit and navigation pulses
//   preset, preset_bus         load all shadow fields (field 0 in the MSBs)
//   bus_ack                    bus driver accepted the current phase
//   bus_req, a_d, bus_dout     phase request, phase select (0 addr / 1 data), phase payload
//   cursor, field_values       selected field and shadow register contents
//   busy, done, err            write in flight, write-complete pulse, timeout-abort pulse
module rtc_field_editor #(
    parameter int unsigned          NFIELDS   = 3,
    parameter int unsigned          CW        = 2,
    parameter logic [8*NFIELDS-1:0] MAX_LIST  = {8'h23, 8'h59, 8'h59},
    parameter logic [8*NFIELDS-1:0] ADDR_LIST = {8'h43, 8'h42, 8'h41},
    parameter int unsigned          TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic                   preset,
    input  logic [8*NFIELDS-1:0]   preset_bus,
    input  logic                   bus_ack,
    output logic                   bus_req,
    output logic                   a_d,
    output logic [7:0]             bus_dout,
    output logic [CW-1:0]          cursor,
    output logic [8*NFIELDS-1:0]   field_values,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned TW      = 16;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_ADDR, S_DATA} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cursor_q, cursor_d;
    logic [7:0]     shadow_q [NFIELDS];
    logic [7:0]     shadow_d [NFIELDS];
    logic [TW-1:0]  cnt_q, cnt_d;
    logic           bus_req_q, bus_req_d;
    logic           a_d_q, a_d_d;
    logic [7:0]     bus_dout_q, bus_dout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           to_sel_c;

    logic [7:0]     max_a    [NFIELDS];
    logic [7:0]     addr_a   [NFIELDS];
    logic [7:0]     preset_a [NFIELDS];

    // Unpack per-field constants and buses; field 0 sits in the MSBs.
    for (genvar g = 0; g < NFIELDS; g++) begin : g_unpack
        assign max_a[g]    = MAX_LIST[8*(NFIELDS-1-g) +: 8];
        assign addr_a[g]   = ADDR_LIST[8*(NFIELDS-1-g) +: 8];
        assign preset_a[g] = preset_bus[8*(NFIELDS-1-g) +: 8];
        assign field_values[8*(NFIELDS-1-g) +: 8] = shadow_q[g];
    end

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
        if (v == mx)             return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
        if (v == 8'h00)          return mx;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Malformed or out-of-range preset values collapse to zero.
    function automatic logic [7:0] bcd_clip(input logic [7:0] v, input logic [7:0] mx);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > mx) return 8'h00;
        else                                           return v;
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        shadow_d   = shadow_q;
        cnt_d      = cnt_q;
        bus_req_d  = bus_req_q;
        a_d_d      = a_d_q;
        bus_dout_d = bus_dout_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        to_sel_c   = 1'b0;

        if (preset && (state_q == S_IDLE || state_q == S_SEL)) begin
            for (int i = 0; i < NFIELDS; i++) begin
                shadow_d[i] = bcd_clip(preset_a[i], max_a[i]);
            end
        end

        if (!enable) begin
            // Abandon any transaction silently; shadows are kept.
            state_d    = S_IDLE;
            bus_req_d  = 1'b0;
            a_d_d      = 1'b0;
            bus_dout_d = 8'h00;
            busy_d     = 1'b0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_SEL;
                    cursor_d = '0;
                end
                S_SEL: begin
                    // A preset cycle carries no button event.
                    if (!preset) begin
                        if (up ^ down) begin
                            shadow_d[cursor_q] = up ? bcd_inc(shadow_q[cursor_q], max_a[cursor_q])
                                                    : bcd_dec(shadow_q[cursor_q], max_a[cursor_q]);
                            state_d    = S_ADDR;
                            bus_req_d  = 1'b1;
                            a_d_d      = 1'b0;
                            bus_dout_d = addr_a[cursor_q];
                            busy_d     = 1'b1;
                            cnt_d      = '0;
                        end else if (!(up & down) && (left ^ right)) begin
                            if (left) begin
                                cursor_d = (cursor_q == '0) ? CW'(NFIELDS - 1) : cursor_q - CW'(1);
                            end else begin
                                cursor_d = (cursor_q == CW'(NFIELDS - 1)) ? '0 : cursor_q + CW'(1);
                            end
                        end
                    end
                end
                S_ADDR: begin
                    if (bus_ack) begin
                        state_d    = S_DATA;
                        a_d_d      = 1'b1;
                        bus_dout_d = shadow_q[cursor_q];
                        cnt_d      = '0;
                    end else if (cnt_q == TO_LAST) begin
                        to_sel_c = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (bus_ack) begin
                        to_sel_c = 1'b1;
                        done_d   = 1'b1;
                    end else if (cnt_q == TO_LAST) begin
                        to_sel_c = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Common exit from a transaction, whether completed or timed out.
            if (to_sel_c) begin
                state_d    = S_SEL;
                bus_req_d  = 1'b0;
                a_d_d      = 1'b0;
                bus_dout_d = 8'h00;
                busy_d     = 1'b0;
                cnt_d      = '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cursor_q   <= '0;
            cnt_q      <= '0;
            bus_req_q  <= 1'b0;
            a_d_q      <= 1'b0;
            bus_dout_q <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < NFIELDS; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            cnt_q      <= cnt_d;
            bus_req_q  <= bus_req_d;
            a_d_q      <= a_d_d;
            bus_dout_q <= bus_dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            shadow_q   <= shadow_d;
        end
    end

    assign bus_req  = bus_req_q;
    assign a_d      = a_d_q;
    assign bus_dout = bus_dout_q;
    assign cursor   = cursor_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rtc_field_editor.sv
// Testbench for rtc_field_editor: directed scenarios followed by random stimulus,
// all checked every cycle against a decimal-arithmetic reference model.
module tb_rtc_field_editor;

    localparam int unsigned NF = 3;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic        preset = 1'b0;
    logic [23:0] preset_bus = 24'h0;
    logic        bus_ack = 1'b0;
    logic        bus_req, a_d, busy, done, err;
    logic [7:0]  bus_dout;
    logic [1:0]  cursor;
    logic [23:0] field_values;

    always #5 clk = ~clk;

    rtc_field_editor #(
        .NFIELDS  (3),
        .CW       (2),
        .MAX_LIST (24'h235959),
        .ADDR_LIST(24'h434241),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .preset      (preset),
        .preset_bus  (preset_bus),
        .bus_ack     (bus_ack),
        .bus_req     (bus_req),
        .a_d         (a_d),
        .bus_dout    (bus_dout),
        .cursor      (cursor),
        .field_values(field_values),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fields held as plain decimal numbers.
    int MAXD [NF]  = '{23, 59, 59};
    int ADDRS [NF] = '{'h43, 'h42, 'h41};
    int   m_fv [NF] = '{0, 0, 0};
    int   m_cur = 0;
    int   m_wait = 0;
    bit   m_active = 0, m_writing = 0, m_data_phase = 0;
    bit   m_req = 0, m_ad = 0, m_done = 0, m_err = 0;
    int   m_dout = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [23:0] model_fields();
        return {to_bcd(m_fv[0]), to_bcd(m_fv[1]), to_bcd(m_fv[2])};
    endfunction

    task automatic end_write();
        m_writing = 0; m_req = 0; m_ad = 0; m_dout = 0; m_wait = 0;
    endtask

    task automatic step_model();
        int hi, lo, v;
        m_done = 0;
        m_err  = 0;
        if (reset) begin
            m_fv = '{0, 0, 0}; m_cur = 0; m_active = 0; m_data_phase = 0;
            end_write();
            return;
        end
        if (preset && !m_writing) begin
            for (int i = 0; i < NF; i++) begin
                hi = int'(preset_bus[8*(NF-1-i)+4 +: 4]);
                lo = int'(preset_bus[8*(NF-1-i) +: 4]);
                v  = hi * 10 + lo;
                m_fv[i] = (hi > 9 || lo > 9 || v > MAXD[i]) ? 0 : v;
            end
        end
        if (!enable) begin
            m_active = 0;
            end_write();
            return;
        end
        if (!m_active) begin
            m_active = 1;
            m_cur = 0;
            return;
        end
        if (!m_writing) begin
            if (preset) begin
            end else if (up != down) begin
                if (up) m_fv[m_cur] = (m_fv[m_cur] == MAXD[m_cur]) ? 0 : m_fv[m_cur] + 1;
                else    m_fv[m_cur] = (m_fv[m_cur] == 0) ? MAXD[m_cur] : m_fv[m_cur] - 1;
                m_writing = 1; m_data_phase = 0; m_wait = 0;
                m_req = 1; m_ad = 0; m_dout = ADDRS[m_cur];
            end else if (!(up && down) && (left != right)) begin
                m_cur = left ? (m_cur + NF - 1) % NF : (m_cur + 1) % NF;
            end
        end else if (bus_ack) begin
            if (!m_data_phase) begin
                m_data_phase = 1; m_ad = 1; m_dout = int'(to_bcd(m_fv[m_cur])); m_wait = 0;
            end else begin
                end_write();
                m_done = 1;
            end
        end else begin
            m_wait++;
            if (m_wait >= TO) begin
                end_write();
                m_err = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        check_val("cursor",       32'(cursor),       32'(m_cur));
        check_val("field_values", 32'(field_values), 32'(model_fields()));
        check_val("bus_req",      32'(bus_req),      32'(m_req));
        check_val("a_d",          32'(a_d),          32'(m_ad));
        check_val("busy",         32'(busy),         32'(m_writing));
        check_val("done",         32'(done),         32'(m_done));
        check_val("err",          32'(err),          32'(m_err));
        if (m_req) check_val("bus_dout", 32'(bus_dout), 32'(m_dout));
    endtask

    // One clock: check what the last edge produced, then drive the next inputs.
    task automatic tick(input bit r, input bit en, input bit u, input bit d, input bit l,
                        input bit rt, input bit pr, input logic [23:0] pb, input bit ack);
        @(negedge clk);
        compare_outputs();
        reset = r; enable = en; up = u; down = d; left = l; right = rt;
        preset = pr; preset_bus = pb; bus_ack = ack;
        step_model();
    endtask

    task automatic nop();
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 0);
    endtask

    initial begin
        int ack_pct;
        logic [23:0] pb;

        // Reset, enable with preset, basic minute wrap and full write.
        tick(1, 0, 0, 0, 0, 0, 0, 24'h0, 0);
        tick(0, 1, 0, 0, 0, 0, 1, 24'h235959, 0);
        tick(0, 1, 0, 0, 0, 1, 0, 24'h0, 0);
        tick(0, 1, 1, 0, 0, 0, 0, 24'h0, 0);
        nop();
        check_val("basic_cursor", 32'(cursor), 32'h1);
        check_val("basic_wrap", 32'(field_values), 32'h230059);
        check_val("basic_addr", 32'(bus_dout), 32'h42);
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 1);
        nop();
        check_val("basic_data_ad", 32'(a_d), 32'h1);
        check_val("basic_data", 32'(bus_dout), 32'h00);
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 1);
        nop();
        check_val("basic_done", 32'(done), 32'h1);
        check_val("basic_busy", 32'(busy), 32'h0);

        // BCD carry 09 -> 10 in field 1.
        tick(0, 1, 0, 0, 0, 0, 1, 24'h000900, 0);
        tick(0, 1, 1, 0, 0, 0, 0, 24'h0, 0);
        nop();
        check_val("bcd_carry", 32'(field_values), 32'h001000);
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 1);
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 1);
        nop();

        // Hours 00 -> 23 on down, then never ack: timeout after TO cycles.
        tick(0, 1, 0, 0, 1, 0, 0, 24'h0, 0);
        tick(0, 1, 0, 1, 0, 0, 0, 24'h0, 0);
        nop(); nop(); nop(); nop();
        check_val("to_not_yet", 32'(err), 32'h0);
        check_val("to_req_held", 32'(bus_req), 32'h1);
        nop();
        check_val("to_err", 32'(err), 32'h1);
        check_val("to_req_low", 32'(bus_req), 32'h0);
        check_val("to_kept", 32'(field_values), 32'h231000);

        // Invalid presets load zero.
        tick(0, 1, 0, 0, 0, 0, 1, 24'h3A5960, 0);
        nop();
        check_val("preset_clip", 32'(field_values), 32'h005900);

        // Cursor wrap and conflicting pulses.
        tick(0, 1, 0, 0, 1, 0, 0, 24'h0, 0);
        nop();
        check_val("left_wrap", 32'(cursor), 32'h2);
        tick(0, 1, 0, 0, 0, 1, 0, 24'h0, 0);
        nop();
        check_val("right_wrap", 32'(cursor), 32'h0);
        tick(0, 1, 1, 1, 0, 0, 0, 24'h0, 0);
        nop();
        check_val("updown_req", 32'(bus_req), 32'h0);
        tick(0, 1, 1, 0, 0, 1, 0, 24'h0, 0);
        nop();
        check_val("upright_cur", 32'(cursor), 32'h0);
        check_val("upright_val", 32'(field_values), 32'h015900);
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 1);
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 1);

        // enable low during DATA abandons silently.
        tick(0, 1, 1, 0, 0, 0, 0, 24'h0, 0);
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 1);
        tick(0, 0, 0, 0, 0, 0, 0, 24'h0, 0);
        nop();
        check_val("abort_req", 32'(bus_req), 32'h0);
        check_val("abort_done", 32'(done), 32'h0);
        check_val("abort_err", 32'(err), 32'h0);

        // Button lockout while a write is in flight.
        tick(0, 1, 0, 0, 0, 0, 1, 24'h101010, 0);
        tick(0, 1, 1, 0, 0, 0, 0, 24'h0, 0);
        tick(0, 1, 1, 0, 0, 0, 0, 24'h0, 0);
        tick(0, 1, 1, 0, 0, 0, 0, 24'h0, 0);
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 1);
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 1);
        nop();
        check_val("lockout_val", 32'(field_values), 32'h111010);

        // Synchronous reset mid-DATA.
        tick(0, 1, 1, 0, 0, 0, 0, 24'h0, 0);
        tick(0, 1, 0, 0, 0, 0, 0, 24'h0, 1);
        tick(1, 1, 0, 0, 0, 0, 0, 24'h0, 0);
        nop();
        check_val("rst_fields", 32'(field_values), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);

        // Random traffic with varying ack responsiveness.
        ack_pct = 30;
        for (int c = 0; c < 4000; c++) begin
            if (c % 25 == 0) ack_pct = (c % 75 == 0) ? 0 : (c % 50 == 0 ? 15 : 60);
            if ($urandom_range(0, 1) == 0) pb = 24'($urandom);
            else pb = {to_bcd(int'($urandom_range(0, 23))), to_bcd(int'($urandom_range(0, 59))),
                       to_bcd(int'($urandom_range(0, 59)))};
            tick($urandom_range(0, 399) == 0,
                 $urandom_range(0, 49) != 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 24) == 0,
                 pb,
                 int'($urandom_range(0, 99)) < ack_pct);
        end
        @(negedge clk);
        compare_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
